// File: rtl/descrambler_8bit.sv
// Receive-side 8-bit descrambler: regenerates the X^16+X^5+X^4+X^3+1 sequence,
// re-seeds on COM, freezes on SKIP, and tracks symbol lock with a COM timeout.
module descrambler_8bit #(
  parameter logic [15:0] SEED         = 16'hFFFF,
  parameter logic [7:0]  COM          = 8'hBC,
  parameter logic [7:0]  SKIP         = 8'h1C,
  parameter int          LOCK_TIMEOUT = 1024,
  localparam int         CW           = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] din,
  input  logic       k_in,
  input  logic       dis_scrambler_in,
  output logic       valid_out,
  output logic [7:0] dout,
  output logic       k_out,
  output logic       dis_scrambler_out,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d, lfsr_adv;
  logic [CW-1:0]  count_q, count_d;
  logic           valid_q, valid_d;
  logic [7:0]     dout_q, dout_d;
  logic           k_q, k_d;
  logic           dis_q, dis_d;
  logic           sync_err_q, sync_err_d;
  logic           is_com, is_skip;

  assign is_com  = valid_in & k_in & (din == COM);
  assign is_skip = valid_in & k_in & (din == SKIP);

  // Eight serial shifts of the LFSR collapsed into one parallel step.
  always_comb begin
    lfsr_adv      = '0;
    lfsr_adv[0]   = lfsr_q[8];
    lfsr_adv[1]   = lfsr_q[9];
    lfsr_adv[2]   = lfsr_q[10];
    lfsr_adv[3]   = lfsr_q[8] ^ lfsr_q[11];
    lfsr_adv[4]   = lfsr_q[8] ^ lfsr_q[9] ^ lfsr_q[12];
    lfsr_adv[5]   = lfsr_q[8] ^ lfsr_q[9] ^ lfsr_q[10] ^ lfsr_q[13];
    lfsr_adv[6]   = lfsr_q[9] ^ lfsr_q[10] ^ lfsr_q[11] ^ lfsr_q[14];
    lfsr_adv[7]   = lfsr_q[10] ^ lfsr_q[11] ^ lfsr_q[12] ^ lfsr_q[15];
    lfsr_adv[8]   = lfsr_q[0] ^ lfsr_q[11] ^ lfsr_q[12] ^ lfsr_q[13];
    lfsr_adv[9]   = lfsr_q[1] ^ lfsr_q[12] ^ lfsr_q[13] ^ lfsr_q[14];
    lfsr_adv[10]  = lfsr_q[2] ^ lfsr_q[13] ^ lfsr_q[14] ^ lfsr_q[15];
    lfsr_adv[11]  = lfsr_q[3] ^ lfsr_q[14] ^ lfsr_q[15];
    lfsr_adv[12]  = lfsr_q[4] ^ lfsr_q[15];
    lfsr_adv[13]  = lfsr_q[5];
    lfsr_adv[14]  = lfsr_q[6];
    lfsr_adv[15]  = lfsr_q[7];
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = valid_in;
    dout_d     = dout_q;
    k_d        = k_q;
    dis_d      = dis_q;
    sync_err_d = 1'b0;

    if (is_com)                 lfsr_d = SEED;
    else if (valid_in & !is_skip) lfsr_d = lfsr_adv;

    if (valid_in) begin
      k_d    = k_in;
      dis_d  = dis_scrambler_in;
      dout_d = (k_in | dis_scrambler_in | (state_q != LOCKED)) ? din : (din ^ lfsr_q[7:0]);
    end

    // Lock tracking: any valid non-COM symbol in LOCKED counts toward the timeout.
    if (is_com) begin
      state_d = LOCKED;
      count_d = '0;
    end else if (valid_in && state_q == LOCKED) begin
      if (count_q + 1'b1 == CW'(LOCK_TIMEOUT)) begin
        state_d    = UNLOCKED;
        count_d    = '0;
        sync_err_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      lfsr_q     <= SEED;
      count_q    <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      k_q        <= 1'b0;
      dis_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      k_q        <= k_d;
      dis_q      <= dis_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign valid_out         = valid_q;
  assign dout              = dout_q;
  assign k_out             = k_q;
  assign dis_scrambler_out = dis_q;
  assign locked            = (state_q == LOCKED);
  assign sync_err          = sync_err_q;

endmodule

// File: tb/tb_descrambler_8bit.sv
// Directed bench for descrambler_8bit; LFSR byte sequence after COM from the
// next-state equations: FF, 17, 28, 4B.
module tb_descrambler_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] din;
  logic       k_in;
  logic       dis_scrambler_in;
  logic       valid_out;
  logic [7:0] dout;
  logic       k_out;
  logic       dis_scrambler_out;
  logic       locked;
  logic       sync_err;

  int n_chk  = 0;
  int n_fail = 0;

  descrambler_8bit #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .k_in(k_in),
    .dis_scrambler_in(dis_scrambler_in), .valid_out(valid_out), .dout(dout),
    .k_out(k_out), .dis_scrambler_out(dis_scrambler_out), .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked at the same point.
  task automatic step(input logic v, input logic [7:0] d, input logic k, input logic dis);
    valid_in = v; din = d; k_in = k; dis_scrambler_in = dis;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic sym(input logic [7:0] d, input logic k, input logic dis,
                     input string tag, input logic [7:0] exp_d);
    step(1'b1, d, k, dis);
    chk({tag, "_vld"}, 16'(valid_out), 16'd1);
    chk({tag, "_dout"}, 16'(dout), 16'(exp_d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"},    16'(valid_out), 16'd0);
    chk({tag, "_dout"},   16'(dout), 16'h0);
    chk({tag, "_k"},      16'(k_out), 16'd0);
    chk({tag, "_dis"},    16'(dis_scrambler_out), 16'd0);
    chk({tag, "_locked"}, 16'(locked), 16'd0);
    chk({tag, "_serr"},   16'(sync_err), 16'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; din = '0; k_in = 1'b0; dis_scrambler_in = 1'b0;
    #1;
    do_reset();
    chk_reset_outs("rst");

    // Basic sequence after COM
    sym(8'hBC, 1'b1, 1'b0, "t1_com", 8'hBC);
    chk("t1_com_k", 16'(k_out), 16'd1);
    chk("t1_com_lock", 16'(locked), 16'd1);
    sym(8'h00, 1'b0, 1'b0, "t1_d0", 8'hFF);
    chk("t1_d0_k", 16'(k_out), 16'd0);
    sym(8'h00, 1'b0, 1'b0, "t1_d1", 8'h17);
    sym(8'h00, 1'b0, 1'b0, "t1_d2", 8'h28);

    // SKIP freezes the LFSR
    sym(8'hBC, 1'b1, 1'b0, "t2_com", 8'hBC);
    sym(8'h00, 1'b0, 1'b0, "t2_d0", 8'hFF);
    sym(8'h1C, 1'b1, 1'b0, "t2_skp", 8'h1C);
    chk("t2_skp_k", 16'(k_out), 16'd1);
    sym(8'h00, 1'b0, 1'b0, "t2_d1", 8'h17);

    // Scrambler disable passes data but the LFSR still advances
    sym(8'hBC, 1'b1, 1'b0, "t3_com", 8'hBC);
    sym(8'h5A, 1'b0, 1'b1, "t3_dis", 8'h5A);
    chk("t3_dis_out", 16'(dis_scrambler_out), 16'd1);
    sym(8'h00, 1'b0, 1'b0, "t3_d1", 8'h17);
    chk("t3_dis_out0", 16'(dis_scrambler_out), 16'd0);

    // Data before any COM passes raw
    do_reset();
    sym(8'h00, 1'b0, 1'b0, "t4_pre", 8'h00);
    chk("t4_pre_lock", 16'(locked), 16'd0);
    sym(8'hBC, 1'b1, 1'b0, "t4_com", 8'hBC);
    sym(8'h00, 1'b0, 1'b0, "t4_d0", 8'hFF);

    // Timeout after 4 non-COM symbols
    sym(8'hBC, 1'b1, 1'b0, "t5_com", 8'hBC);
    sym(8'h00, 1'b0, 1'b0, "t5_d0", 8'hFF);
    chk("t5_d0_serr", 16'(sync_err), 16'd0);
    sym(8'h00, 1'b0, 1'b0, "t5_d1", 8'h17);
    sym(8'h00, 1'b0, 1'b0, "t5_d2", 8'h28);
    chk("t5_d2_lock", 16'(locked), 16'd1);
    chk("t5_d2_serr", 16'(sync_err), 16'd0);
    sym(8'h00, 1'b0, 1'b0, "t5_d3", 8'h4B);
    chk("t5_d3_serr", 16'(sync_err), 16'd1);
    chk("t5_d3_lock", 16'(locked), 16'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_idle_serr", 16'(sync_err), 16'd0);
    sym(8'h00, 1'b0, 1'b0, "t5_raw", 8'h00);
    chk("t5_raw_lock", 16'(locked), 16'd0);

    // valid_in gaps freeze everything
    sym(8'hBC, 1'b1, 1'b0, "t6_com", 8'hBC);
    sym(8'h00, 1'b0, 1'b0, "t6_d0", 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hA5, 1'b1, 1'b1);
      chk("t6_gap_vld", 16'(valid_out), 16'd0);
      chk("t6_gap_dout", 16'(dout), 16'hFF);
      chk("t6_gap_k", 16'(k_out), 16'd0);
    end
    sym(8'h00, 1'b0, 1'b0, "t6_d1", 8'h17);

    // Reset mid-stream discards the in-flight symbol
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk_reset_outs("t6_rst");
    rst = 1'b0;
    sym(8'h00, 1'b0, 1'b0, "t6_post", 8'h00);
    chk("t6_post_lock", 16'(locked), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
